// File: rtl/gshare_pht_if.sv
// Fetch/EX-side bus of the gshare predictor: lookup request, registered
// prediction, resolved-branch training and init status.
interface gshare_pht_if #(
    parameter int HISTORY_SIZE = 64,
    parameter int INDEX_BITS   = 10,
    parameter int PC_WIDTH     = 32
);
    logic [HISTORY_SIZE-1:0] history;
    logic                    req_valid;
    logic [PC_WIDTH-1:0]     req_pc;
    logic                    pred_valid;
    logic                    pred_taken;
    logic [INDEX_BITS-1:0]   pred_index;
    logic                    upd_valid;
    logic [INDEX_BITS-1:0]   upd_index;
    logic                    upd_taken;
    logic                    init_busy;

    modport master (
        output history, req_valid, req_pc, upd_valid, upd_index, upd_taken,
        input  pred_valid, pred_taken, pred_index, init_busy
    );
    modport slave (
        input  history, req_valid, req_pc, upd_valid, upd_index, upd_taken,
        output pred_valid, pred_taken, pred_index, init_busy
    );
endinterface

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit
// saturating counters; a sequencer clears the table to weak-NT after reset.
module gshare_pht #(
    parameter int HISTORY_SIZE = 64,
    parameter int INDEX_BITS   = 10,
    parameter int PC_WIDTH     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    gshare_pht_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] ptr;
    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] waddr;
    logic [1:0]            wdata;
    logic [1:0]            upd_ctr;
    logic                  we;
    logic [1:0]            pht [ENTRIES];
    logic                  unused_bits;

    assign idx         = bus.req_pc[INDEX_BITS+1:2] ^ bus.history[INDEX_BITS-1:0];
    assign upd_ctr     = pht[bus.upd_index];
    assign unused_bits = ^{bus.history, bus.req_pc};

    // One write port: the clear sweep owns it during INIT, training afterwards.
    always_comb begin
        we    = 1'b0;
        waddr = ptr;
        wdata = 2'b01;
        if (rst_n) begin
            if (state == INIT) begin
                we = 1'b1;
            end else if (bus.upd_valid) begin
                we    = 1'b1;
                waddr = bus.upd_index;
                if (bus.upd_taken)
                    wdata = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
                else
                    wdata = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            pht[waddr] <= wdata;
    end

    // Lookup reads the array before this edge's write, so a same-cycle
    // collision naturally returns the old counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= INIT;
            ptr            <= '0;
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_index <= '0;
            bus.init_busy  <= 1'b1;
        end else begin
            bus.pred_valid <= bus.req_valid;
            if (bus.req_valid) begin
                bus.pred_index <= idx;
                bus.pred_taken <= (state == READY) && pht[idx][1];
            end
            if (state == INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == '1) begin
                    state         <= READY;
                    bus.init_busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with hand-computed counter states.
module tb_gshare_pht;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cnt;

    gshare_pht_if #(.HISTORY_SIZE(64), .INDEX_BITS(10), .PC_WIDTH(32)) bif ();

    gshare_pht #(.HISTORY_SIZE(64), .INDEX_BITS(10), .PC_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] pc, input logic [63:0] hist);
        bif.req_valid = 1'b1;
        bif.req_pc    = pc;
        bif.history   = hist;
        tick();
        bif.req_valid = 1'b0;
    endtask

    // n back-to-back updates with upd_valid held high
    task automatic do_upd(input logic [9:0] index, input logic taken, input int n);
        bif.upd_valid = 1'b1;
        bif.upd_index = index;
        bif.upd_taken = taken;
        repeat (n) tick();
        bif.upd_valid = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        cnt = 0;
        while (bif.init_busy && cnt < 2000) begin
            cnt++;
            tick();
        end
        chk(tag, cnt, 1024);
    endtask

    initial begin
        rst_n         = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_pc    = '0;
        bif.history   = '0;
        bif.upd_valid = 1'b0;
        bif.upd_index = '0;
        bif.upd_taken = 1'b0;
        tick();
        tick();
        chk("rst_pred_valid", bif.pred_valid, 0);
        chk("rst_pred_taken", bif.pred_taken, 0);
        chk("rst_pred_index", bif.pred_index, 0);
        chk("rst_init_busy",  bif.init_busy, 1);

        // Request in first init cycle; updates must be ignored during init.
        rst_n = 1'b1;
        chk("init_busy_first", bif.init_busy, 1);
        bif.upd_valid = 1'b1;
        bif.upd_index = 10'h013;
        bif.upd_taken = 1'b1;
        do_req(32'h0000_0040, 64'h3);
        bif.upd_valid = 1'b0;
        cnt = 1;
        chk("init_req_valid", bif.pred_valid, 1);
        chk("init_req_taken", bif.pred_taken, 0);
        chk("init_req_index", bif.pred_index, 10'h013);
        while (bif.init_busy && cnt < 2000) begin
            cnt++;
            tick();
        end
        chk("init_len", cnt, 1024);

        // Basic lookup, hold behaviour, one taken update.
        do_req(32'h0000_0040, 64'h0);
        chk("lk_valid", bif.pred_valid, 1);
        chk("lk_index", bif.pred_index, 10'h010);
        chk("lk_taken", bif.pred_taken, 0);
        tick();
        chk("idle_valid", bif.pred_valid, 0);
        chk("idle_index_hold", bif.pred_index, 10'h010);
        do_upd(10'h010, 1'b1, 1);
        do_req(32'h0000_0040, 64'h0);
        chk("upd1_taken", bif.pred_taken, 1);

        // Ignored-during-init update at 0x013 must not have landed.
        do_req(32'h0000_0040, 64'h3);
        chk("init_upd_ignored", bif.pred_taken, 0);

        // Saturation at 0x3FF.
        do_upd(10'h3FF, 1'b1, 5);
        do_upd(10'h3FF, 1'b0, 1);
        do_req(32'h0000_0FFC, 64'h0);
        chk("sat_hi_index", bif.pred_index, 10'h3FF);
        chk("sat_hi_taken", bif.pred_taken, 1);
        do_upd(10'h3FF, 1'b0, 3);
        do_upd(10'h3FF, 1'b1, 1);
        do_req(32'h0000_0FFC, 64'h0);
        chk("sat_lo_taken", bif.pred_taken, 0);

        // Hash with high history bits that must not matter; independent training.
        do_req(32'h0000_0040, 64'hABCD_0000_0000_00FF);
        chk("hash_index", bif.pred_index, 10'h0EF);
        chk("hash_taken", bif.pred_taken, 0);
        do_upd(10'h0EF, 1'b0, 2);
        do_upd(10'h010, 1'b1, 1);
        do_req(32'h0000_0040, 64'h0);
        chk("alias_010", bif.pred_taken, 1);
        do_req(32'h0000_0040, 64'h0FF);
        chk("alias_0ef", bif.pred_taken, 0);
        do_upd(10'h0EF, 1'b1, 1);
        do_req(32'h0000_0040, 64'h0FF);
        chk("alias_0ef_01", bif.pred_taken, 0);

        // Collision: same-cycle request and taken update to 0x020 (counter 01).
        bif.upd_valid = 1'b1;
        bif.upd_index = 10'h020;
        bif.upd_taken = 1'b1;
        do_req(32'h0000_0080, 64'h0);
        bif.upd_valid = 1'b0;
        chk("coll_index", bif.pred_index, 10'h020);
        chk("coll_old", bif.pred_taken, 0);
        do_req(32'h0000_0080, 64'h0);
        chk("coll_new", bif.pred_taken, 1);

        // Reset mid-run: 0x010 is at 11 and must be cleared again.
        rst_n = 1'b0;
        tick();
        chk("rrst_busy", bif.init_busy, 1);
        chk("rrst_valid", bif.pred_valid, 0);
        chk("rrst_index", bif.pred_index, 0);
        rst_n = 1'b1;
        wait_init("reinit_len");
        do_req(32'h0000_0040, 64'h0);
        chk("reinit_010", bif.pred_taken, 0);
        do_req(32'h0000_0080, 64'h0);
        chk("reinit_020", bif.pred_taken, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
